mem_mult_engine: RTL and testbench

MEM_MULT_ENGINE -- requirements
Module: mem_mult_engine

---
 rtl/mult_pkg.sv | 13 +
 rtl/shift_add_mul.sv | 42 ++++
 rtl/mem_mult_engine.sv | 107 ++++++++++
 tb/tb_mem_mult_engine.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM state type, default parameters and latency formula for mem_mult_engine.
package mult_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, MUL, STORE, DONE} state_t;
  localparam int DEF_OPW_BYTES = 2;
  localparam int DEF_NPAIRS = 16;
  localparam int DEF_SRC_BASE = 0;
  localparam int DEF_DST_BASE = 64;
  localparam int DEF_ADDR_W = 8;
  // Cycles from leaving IDLE until done rises: 2B load + 8B multiply + 2B store per pair.
  function automatic int job_latency(input int opw_bytes, input int npairs);
    return npairs * 12 * opw_bytes;
  endfunction
endpackage

// File: rtl/shift_add_mul.sv
// shift_add_mul: iterative unsigned W x W radix-2 shift-add multiplier.
//   clk, reset (sync, active-low), start (loads a/b and performs bit 0),
//   a, b (unsigned operands), busy (steps remaining), product (2W-bit result).
// The first partial product is taken on the start edge, so W-1 further cycles
// of busy follow and product is final in the first cycle busy is low.
module shift_add_mul #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic [2*W-1:0] product
);
  localparam int CW = $clog2(W);
  logic [2*W-1:0] mcand;
  logic [2*W-1:0] acc;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;
  assign busy = cnt != '0;
  assign product = acc;
  always_ff @(posedge clk) begin
    if (!reset) begin
      mcand <= '0;
      acc <= '0;
      mplier <= '0;
      cnt <= '0;
    end else if (start) begin
      acc <= b[0] ? {{W{1'b0}}, a} : '0;
      mcand <= {{W{1'b0}}, a} << 1;
      mplier <= b >> 1;
      cnt <= CW'(W - 1);
    end else if (busy) begin
      acc <= mplier[0] ? acc + mcand : acc;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/mem_mult_engine.sv
// mem_mult_engine: multiplies NPAIRS big-endian operand pairs read from a byte memory
// and writes the 2W-bit big-endian products back.
//   clk, reset (sync, active-low), req (start / hold in DONE), sgn (signed mode),
//   done (high in DONE), mem_addr (shared read/write byte address),
//   mem_rd_data (combinational read data), mem_wr_en / mem_wr_data (byte write port).
module mem_mult_engine
  import mult_pkg::*;
#(
  parameter int OPW_BYTES = DEF_OPW_BYTES,
  parameter int NPAIRS    = DEF_NPAIRS,
  parameter int SRC_BASE  = DEF_SRC_BASE,
  parameter int DST_BASE  = DEF_DST_BASE,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              sgn,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wr_data
);
  localparam int W  = 8 * OPW_BYTES;
  localparam int PB = 2 * OPW_BYTES;
  localparam int CW = $clog2(W);
  localparam int PW = NPAIRS > 1 ? $clog2(NPAIRS) : 1;
  state_t         state;
  logic [CW-1:0]  cnt;
  logic [PW-1:0]  pair;
  logic           sg;
  logic [2*W-1:0] ops;
  logic [2*W-1:0] ops_nx;
  logic [2*W-1:0] prod;
  logic [2*W-1:0] res;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic           start;
  logic           busy;
  logic           last_byte;
  logic           neg;
  int             off;
  // ops_nx includes the byte being read this cycle, so the multiplier can be
  // started on the final LOAD edge without an extra cycle.
  always_comb begin
    ops_nx = {ops[2*W-9:0], mem_rd_data};
    a_mag = sg && ops_nx[2*W-1] ? -ops_nx[2*W-1:W] : ops_nx[2*W-1:W];
    b_mag = sg && ops_nx[W-1] ? -ops_nx[W-1:0] : ops_nx[W-1:0];
    last_byte = cnt == CW'(PB - 1);
    start = state == LOAD && last_byte;
    neg = sg && (ops[2*W-1] ^ ops[W-1]);
    res = neg ? -prod : prod;
    off = PB * int'(pair) + int'(cnt);
    mem_addr = state == LOAD  ? ADDR_W'(SRC_BASE + off) :
               state == STORE ? ADDR_W'(DST_BASE + off) : ADDR_W'(SRC_BASE);
    mem_wr_en = state == STORE;
    mem_wr_data = state == STORE ? 8'(res >> (8 * (PB - 1 - int'(cnt)))) : 8'h00;
  end
  shift_add_mul #(.W(W)) u_mul (
    .clk(clk),
    .reset(reset),
    .start(start),
    .a(a_mag),
    .b(b_mag),
    .busy(busy),
    .product(prod)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      pair <= '0;
      sg <= 1'b0;
      ops <= '0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req) begin
          state <= LOAD;
          sg <= sgn;
          pair <= '0;
          cnt <= '0;
        end
        LOAD: begin
          ops <= ops_nx;
          cnt <= last_byte ? '0 : cnt + 1'b1;
          if (last_byte) state <= MUL;
        end
        MUL: if (!busy) state <= STORE;
        STORE: begin
          cnt <= last_byte ? '0 : cnt + 1'b1;
          if (last_byte) begin
            pair <= pair + 1'b1;
            state <= pair == PW'(NPAIRS - 1) ? DONE : LOAD;
            done <= pair == PW'(NPAIRS - 1);
          end
        end
        DONE: if (!req) begin
          state <= IDLE;
          done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_mult_engine.sv
// tb_mem_mult_engine: scoreboard bench for mem_mult_engine with a byte-memory model.
module tb_mem_mult_engine;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req = 1'b0;
  logic sgn = 1'b0;
  logic done;
  logic mem_wr_en;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic [7:0] mem_wr_data;
  logic req4 = 1'b0;
  logic done4;
  logic wr4;
  logic [7:0] addr4;
  logic [7:0] rd4;
  logic [7:0] wd4;
  logic [7:0] mem [256];
  logic [7:0] img [256];
  logic load_img = 1'b0;
  logic [15:0] sb [$];
  logic [15:0] mon_e;
  int tests = 0;
  int failed = 0;
  int wr_cnt = 0;
  int w4 = 0;
  logic [63:0] got4 = '0;
  logic [7:0] last_a4 = '0;
  logic [63:0] src4 = 64'h8000_0000_0000_0003;
  logic [7:0] snap [64];
  int n, lows, mism, mism2, base;
  bit s, p;

  always #5 clk = ~clk;

  mem_mult_engine dut (
    .clk(clk), .reset(reset), .req(req), .sgn(sgn), .done(done),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data)
  );

  mem_mult_engine #(.OPW_BYTES(4), .NPAIRS(1)) dut4 (
    .clk(clk), .reset(reset), .req(req4), .sgn(1'b1), .done(done4),
    .mem_addr(addr4), .mem_rd_data(rd4),
    .mem_wr_en(wr4), .mem_wr_data(wd4)
  );

  assign mem_rd_data = mem[mem_addr];
  assign rd4 = addr4 < 8'd8 ? 8'(src4 >> (56 - 8 * int'(addr4))) : 8'h00;

  always @(posedge clk) begin
    if (load_img) for (int i = 0; i < 256; i++) mem[i] <= img[i];
    if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    if (wr4) begin
      got4 <= {got4[55:0], wd4};
      last_a4 <= addr4;
      w4 <= w4 + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_wr_en) begin
      wr_cnt++;
      if (sb.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wr_data);
      end else begin
        mon_e = sb.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(mon_e[15:8]));
        check("wr_data", 64'(mem_wr_data), 64'(mon_e[7:0]));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] ref_prod(input bit sm, input logic [15:0] a, input logic [15:0] b);
    longint r;
    r = sm ? longint'($signed(a)) * longint'($signed(b)) : longint'({16'h0, a}) * longint'({16'h0, b});
    return r[31:0];
  endfunction

  function automatic logic [7:0] exp_byte(input bit sm, input int i);
    int j;
    logic [31:0] r;
    j = i / 4;
    r = ref_prod(sm, {img[4*j], img[4*j+1]}, {img[4*j+2], img[4*j+3]});
    return 8'(r >> (8 * (3 - i % 4)));
  endfunction

  function automatic logic [31:0] word(input int a);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'h0001;
      2: return 16'h7FFF;
      3: return 16'h8000;
      4: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic set_pair(input int j, input logic [15:0] a, input logic [15:0] b);
    img[4*j] = a[15:8];
    img[4*j+1] = a[7:0];
    img[4*j+2] = b[15:8];
    img[4*j+3] = b[7:0];
  endtask

  task automatic fill();
    for (int i = 0; i < 256; i++) img[i] = (i >= 64 && i < 128) ? 8'hA5 : 8'($urandom);
    for (int j = 0; j < 16; j++) set_pair(j, pick(), pick());
  endtask

  task automatic load_mem();
    @(negedge clk) load_img = 1'b1;
    @(negedge clk) load_img = 1'b0;
  endtask

  task automatic push_job(input bit sm);
    for (int i = 0; i < 64; i++) sb.push_back({8'(64 + i), exp_byte(sm, i)});
  endtask

  task automatic start_job(input bit sm, input bit pulse);
    @(negedge clk);
    sgn = sm;
    req = 1'b1;
    push_job(sm);
    @(posedge clk);
    #1;
    sgn = ~sm;
    if (pulse) req = 1'b0;
  endtask

  task automatic wait_done(input string name, input int lat);
    int k;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!done && k < 2000);
    check(name, 64'(k), 64'(lat));
    check("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic idle_up();
    @(negedge clk) req = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", 64'(done), 64'd0);
    check("rst_wr_en", 64'(mem_wr_en), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_wr_data", 64'(mem_wr_data), 64'd0);
    check("rst_done4", 64'(done4), 64'd0);
    @(negedge clk) reset = 1'b1;
    load_mem();

    @(negedge clk) req4 = 1'b1;
    @(posedge clk);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done4 && n < 200);
    check("w4_latency", 64'(n), 64'd48);
    check("w4_product", got4, 64'hFFFF_FFFE_8000_0000);
    check("w4_writes", 64'(w4), 64'd8);
    check("w4_last_addr", 64'(last_a4), 64'd71);
    req4 = 1'b0;

    fill();
    set_pair(0, 16'd3, 16'hFFFB);
    set_pair(1, 16'd0, 16'd1234);
    set_pair(2, 16'hFFFF, 16'hFFFF);
    set_pair(3, 16'h8000, 16'h8000);
    set_pair(4, 16'h7FFF, 16'h8000);
    set_pair(5, 16'hFFFF, 16'hFFFF);
    load_mem();
    start_job(1'b1, 1'b0);
    wait_done("signed_latency", 384);
    check("s_3_x_m5", 64'(word(64)), 64'hFFFF_FFF1);
    check("s_0_x_1234", 64'(word(68)), 64'h0);
    check("s_m1_x_m1", 64'(word(72)), 64'h1);
    check("s_min_x_min", 64'(word(76)), 64'h4000_0000);
    check("s_max_x_min", 64'(word(80)), 64'hC000_8000);
    check("s_ffff_x_ffff", 64'(word(84)), 64'h1);

    lows = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (!done) lows++;
    end
    check("done_held", 64'(lows), 64'd0);
    @(negedge clk) req = 1'b0;
    @(posedge clk);
    #1;
    check("done_drop", 64'(done), 64'd0);
    for (int i = 0; i < 64; i++) snap[i] = mem[64+i];
    start_job(1'b1, 1'b0);
    wait_done("rerun_latency", 384);
    mism = 0;
    for (int i = 0; i < 64; i++) if (mem[64+i] !== snap[i]) mism++;
    check("rerun_identical", 64'(mism), 64'd0);
    idle_up();

    start_job(1'b0, 1'b1);
    wait_done("unsigned_latency", 384);
    @(posedge clk);
    #1;
    check("pulse_to_idle", 64'(done), 64'd0);
    check("u_ffff_x_ffff", 64'(word(84)), 64'hFFFE_0001);
    check("u_3_x_fffb", 64'(word(64)), 64'h0002_FFF1);
    idle_up();

    repeat (2) begin
      fill();
      load_mem();
      s = 1'($urandom);
      p = 1'($urandom);
      start_job(s, p);
      wait_done("random_latency", 384);
      idle_up();
    end

    fill();
    load_mem();
    base = wr_cnt;
    start_job(1'b1, 1'b0);
    n = 0;
    while (wr_cnt < base + 22 && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("reached_pair5_store", 64'(wr_cnt - base), 64'd22);
    reset = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_wr_en", 64'(mem_wr_en), 64'd0);
    check("midrst_addr", 64'(mem_addr), 64'd0);
    mism = 0;
    mism2 = 0;
    for (int i = 0; i < 22; i++) if (mem[64+i] !== exp_byte(1'b1, i)) mism++;
    for (int i = 22; i < 64; i++) if (mem[64+i] !== 8'hA5) mism2++;
    check("midrst_written_kept", 64'(mism), 64'd0);
    check("midrst_unwritten_clean", 64'(mism2), 64'd0);
    @(negedge clk);
    sgn = 1'b0;
    push_job(1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("held_rst_done", 64'(done), 64'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    sgn = 1'b1;
    wait_done("restart_latency", 384);
    idle_up();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
